// File: rtl/jtframe_bram_bank.sv
// ============================================================================
// jtframe_bram_bank
//   One SDRAM-style request bank backed by block RAM; also serves the
//   ROM-download port with the loader timing of the SDRAM path.
//   Rev 1.0
// ============================================================================
`default_nettype none

module jtframe_bram_bank #(
  parameter int AW      = 12,
  parameter int BURST   = 2,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [15:0]   din,
  input  logic [1:0]    din_m,
  output logic          ack,
  output logic          dst,
  output logic          dok,
  output logic          rdy,
  output logic [15:0]   dout,
  input  logic          prog_en,
  input  logic [AW-1:0] prog_addr,
  input  logic          prog_we,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  output logic          prog_ack,
  output logic          prog_rdy
);

  localparam int c_cw = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_cw-1:0] c_lat_last  = c_cw'(LATENCY - 1);
  localparam logic [1:0]      c_last_beat = 2'(BURST - 1);

  typedef enum logic [2:0] {IDLE, WAIT, DATA, WDONE, PDONE} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_PROG} op_t;

  logic [15:0]   r_mem [0:(1<<AW)-1];

  state_t        r_state, state_nx;
  op_t           r_op, op_nx;
  logic [AW-1:0] r_addr, addr_nx;
  logic [15:0]   r_data, data_nx;
  logic [1:0]    r_mask, mask_nx;
  logic [c_cw-1:0] r_cnt, cnt_nx;
  logic [1:0]    r_beat, beat_nx;
  logic          ack_nx, dst_nx, dok_nx, rdy_nx, pack_nx, prdy_nx;
  logic          w_load, w_mem_we;

  always_comb begin
    state_nx = r_state;
    op_nx    = r_op;
    addr_nx  = r_addr;
    data_nx  = r_data;
    mask_nx  = r_mask;
    cnt_nx   = r_cnt;
    beat_nx  = r_beat;
    ack_nx   = 1'b0;
    dst_nx   = 1'b0;
    dok_nx   = 1'b0;
    rdy_nx   = 1'b0;
    pack_nx  = 1'b0;
    prdy_nx  = 1'b0;
    w_load   = 1'b0;
    w_mem_we = 1'b0;
    case (r_state)
      IDLE: begin
        cnt_nx  = '0;
        beat_nx = '0;
        if (prog_en && prog_we) begin
          op_nx    = OP_PROG;
          addr_nx  = prog_addr;
          data_nx  = prog_data;
          mask_nx  = prog_mask;
          pack_nx  = 1'b1;
          state_nx = WAIT;
        end else if (!prog_en && wr) begin
          op_nx    = OP_WR;
          addr_nx  = addr;
          data_nx  = din;
          mask_nx  = din_m;
          ack_nx   = 1'b1;
          state_nx = WAIT;
        end else if (!prog_en && rd) begin
          op_nx    = OP_RD;
          addr_nx  = addr;
          ack_nx   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (r_op == OP_RD) begin
          // Last latency cycle fetches word 0 so it appears LATENCY cycles after ack
          if (r_cnt == c_lat_last) begin
            w_load   = 1'b1;
            dok_nx   = 1'b1;
            dst_nx   = 1'b1;
            rdy_nx   = (c_last_beat == 2'd0);
            addr_nx  = r_addr + AW'(1);
            state_nx = DATA;
          end else begin
            cnt_nx = r_cnt + c_cw'(1);
          end
        end else begin
          w_mem_we = 1'b1;
          if (r_op == OP_PROG) begin
            prdy_nx  = 1'b1;
            state_nx = PDONE;
          end else begin
            rdy_nx   = 1'b1;
            state_nx = WDONE;
          end
        end
      end
      DATA: begin
        if (r_beat == c_last_beat) begin
          state_nx = IDLE;
        end else begin
          w_load  = 1'b1;
          dok_nx  = 1'b1;
          beat_nx = r_beat + 2'd1;
          rdy_nx  = (r_beat + 2'd1 == c_last_beat);
          addr_nx = r_addr + AW'(1);
        end
      end
      WDONE, PDONE: state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_RD;
      r_addr   <= '0;
      r_data   <= '0;
      r_mask   <= '0;
      r_cnt    <= '0;
      r_beat   <= '0;
      ack      <= 1'b0;
      dst      <= 1'b0;
      dok      <= 1'b0;
      rdy      <= 1'b0;
      prog_ack <= 1'b0;
      prog_rdy <= 1'b0;
      dout     <= '0;
    end else begin
      r_state  <= state_nx;
      r_op     <= op_nx;
      r_addr   <= addr_nx;
      r_data   <= data_nx;
      r_mask   <= mask_nx;
      r_cnt    <= cnt_nx;
      r_beat   <= beat_nx;
      ack      <= ack_nx;
      dst      <= dst_nx;
      dok      <= dok_nx;
      rdy      <= rdy_nx;
      prog_ack <= pack_nx;
      prog_rdy <= prdy_nx;
      if (w_load) dout <= r_mem[r_addr];
    end
  end

  // Mask bit set means that byte is left untouched
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      if (!r_mask[1]) r_mem[r_addr][15:8] <= r_data[15:8];
      if (!r_mask[0]) r_mem[r_addr][7:0]  <= r_data[7:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtframe_bram_bank.sv
// ============================================================================
// tb_jtframe_bram_bank
//   Self-checking bench: per-scenario tasks against a cycle-plan memory model.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_jtframe_bram_bank;
  localparam int AW = 12;
  localparam int B  = 2;
  localparam int L  = 2;

  logic clk, rst, rd, wr, prog_en, prog_we;
  logic [AW-1:0] addr, prog_addr;
  logic [15:0] din, prog_data, dout;
  logic [1:0] din_m, prog_mask;
  logic ack, dst, dok, rdy, prog_ack, prog_rdy;

  jtframe_bram_bank #(.AW(AW), .BURST(B), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .din(din), .din_m(din_m),
    .ack(ack), .dst(dst), .dok(dok), .rdy(rdy), .dout(dout),
    .prog_en(prog_en), .prog_addr(prog_addr), .prog_we(prog_we),
    .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [15:0] model [0:(1<<AW)-1];
  // strobe vector order: {ack,dst,dok,rdy,prog_ack,prog_rdy}
  logic [5:0]  exp_s [0:39];
  logic [5:0]  got_s [0:39];
  logic [15:0] exp_d [0:39];
  logic [15:0] got_d [0:39];
  bit          exp_dv[0:39];
  logic [15:0] last_dout;
  logic [15:0] cur;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] m);
    return {m[1] ? old[15:8] : d[15:8], m[0] ? old[7:0] : d[7:0]};
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < 40; i++) begin
      exp_s[i] = '0; exp_d[i] = '0; exp_dv[i] = 1'b0;
    end
  endtask

  // Read sampled in cycle s: ack s+1, words at s+1+L+k from wrapped addresses
  task automatic plan_read(input logic [AW-1:0] a, input int s);
    logic [AW-1:0] wa;
    exp_s[s+1][5] = 1'b1;
    for (int k = 0; k < B; k++) begin
      wa = a + AW'(k);
      exp_s[s+1+L+k][3] = 1'b1;
      exp_dv[s+1+L+k]   = 1'b1;
      exp_d[s+1+L+k]    = model[wa];
      if (k == 0)     exp_s[s+1+L+k][4] = 1'b1;
      if (k == B - 1) exp_s[s+1+L+k][2] = 1'b1;
    end
  endtask

  task automatic plan_write(input logic [AW-1:0] a, input logic [15:0] d,
                            input logic [1:0] m, input int s, input bit is_prog);
    if (is_prog) begin exp_s[s+1][1] = 1'b1; exp_s[s+2][0] = 1'b1; end
    else         begin exp_s[s+1][5] = 1'b1; exp_s[s+2][2] = 1'b1; end
    model[a] = merge(model[a], d, m);
  endtask

  // kind: 0 read, 1 game write, 2 loader write; driven at a negedge while idle
  task automatic issue(input int kind, input logic [AW-1:0] a, input logic [15:0] d,
                       input logic [1:0] m, output int n);
    case (kind)
      0: begin addr = a; rd = 1'b1; plan_read(a, 0); n = L + B + 1; end
      1: begin addr = a; din = d; din_m = m; wr = 1'b1; plan_write(a, d, m, 0, 1'b0); n = 3; end
      default: begin
        prog_en = 1'b1; prog_addr = a; prog_data = d; prog_mask = m; prog_we = 1'b1;
        plan_write(a, d, m, 0, 1'b1); n = 3;
      end
    endcase
  endtask

  task automatic run(input int n, input bit drop, input int rst_at, input int prog_at);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      got_s[i] = {ack, dst, dok, rdy, prog_ack, prog_rdy};
      got_d[i] = dout;
      if (drop) begin
        if (ack) begin if (wr) wr = 1'b0; else rd = 1'b0; end
        if (prog_ack) prog_we = 1'b0;
      end
      rst = (i == rst_at);
      if (i == prog_at) begin prog_en = 1'b1; prog_we = 1'b1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 1'b1; addr = 12'h010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ack, dst, dok, rdy, prog_ack, prog_rdy} !== 6'b0) begin
      bad++; $display("FAIL reset strobes got=%b want=000000", {ack, dst, dok, rdy, prog_ack, prog_rdy});
    end
    total++;
    if (dout !== 16'h0) begin bad++; $display("FAIL reset dout got=%h want=0000", dout); end
    rst = 1'b0; rd = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({ack, rdy, prog_ack} !== 3'b0) begin
      bad++; $display("FAIL reset idle got=%b want=000", {ack, rdy, prog_ack});
    end
    last_dout = 16'h0;
  endtask

  task automatic test_prog();
    logic [AW-1:0] pa [6] = '{12'h010, 12'h011, 12'hFFF, 12'h000, 12'h020, 12'h021};
    logic [15:0]   pd [6] = '{16'h1234, 16'h5678, 16'h1111, 16'h2222, 16'hAAAA, 16'hBEEF};
    int n;
    for (int j = 0; j < 6; j++) begin
      clear_plan();
      issue(2, pa[j], pd[j], 2'b00, n);
      run(n, 1'b1, -1, -1);
      prog_en = 1'b0;
      for (int i = 1; i <= n; i++) begin
        total++;
        if (got_s[i] !== exp_s[i]) begin
          bad++; $display("FAIL prog op%0d c%0d strobes got=%b want=%b", j, i, got_s[i], exp_s[i]);
        end
      end
    end
    // Game read must be ignored while the download is active
    clear_plan();
    prog_en = 1'b1; addr = 12'h010; rd = 1'b1;
    run(4, 1'b0, -1, -1);
    rd = 1'b0; prog_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (got_s[i] !== 6'b0) begin
        bad++; $display("FAIL prog_block c%0d strobes got=%b want=000000", i, got_s[i]);
      end
    end
  endtask

  task automatic test_read();
    logic [AW-1:0] ra [4] = '{12'h010, 12'h020, 12'hFFF, 12'h000};
    int n;
    for (int j = 0; j < 4; j++) begin
      clear_plan();
      issue(0, ra[j], 16'h0, 2'b00, n);
      run(n, 1'b1, -1, -1);
      cur = last_dout;
      for (int i = 1; i <= n; i++) begin
        if (exp_dv[i]) cur = exp_d[i];
        total++;
        if (got_s[i] !== exp_s[i]) begin
          bad++; $display("FAIL read op%0d c%0d strobes got=%b want=%b", j, i, got_s[i], exp_s[i]);
        end
        total++;
        if (got_d[i] !== cur) begin
          bad++; $display("FAIL read op%0d c%0d dout got=%h want=%h", j, i, got_d[i], cur);
        end
      end
      last_dout = cur;
    end
  endtask

  task automatic test_write_mask();
    int            kd [4] = '{1, 0, 1, 0};
    logic [15:0]   wd [4] = '{16'hABCD, 16'h0, 16'h9999, 16'h0};
    logic [1:0]    wm [4] = '{2'b10, 2'b00, 2'b11, 2'b00};
    int n;
    for (int j = 0; j < 4; j++) begin
      clear_plan();
      issue(kd[j], 12'h010, wd[j], wm[j], n);
      run(n, 1'b1, -1, -1);
      cur = last_dout;
      for (int i = 1; i <= n; i++) begin
        if (exp_dv[i]) cur = exp_d[i];
        total++;
        if (got_s[i] !== exp_s[i]) begin
          bad++; $display("FAIL wmask op%0d c%0d strobes got=%b want=%b", j, i, got_s[i], exp_s[i]);
        end
        total++;
        if (got_d[i] !== cur) begin
          bad++; $display("FAIL wmask op%0d c%0d dout got=%h want=%h", j, i, got_d[i], cur);
        end
      end
      last_dout = cur;
      if (kd[j] == 0) begin
        total++;
        if (got_d[1+L] !== 16'h12CD) begin
          bad++; $display("FAIL wmask readback op%0d got=%h want=12cd", j, got_d[1+L]);
        end
      end
    end
  endtask

  task automatic test_rd_wr();
    int acks = 0;
    clear_plan();
    addr = 12'h020; din = 16'h00FF; din_m = 2'b00; rd = 1'b1; wr = 1'b1;
    plan_write(12'h020, 16'h00FF, 2'b00, 0, 1'b0);
    plan_read(12'h020, 3);
    run(3 + L + B + 1, 1'b1, -1, -1);
    cur = last_dout;
    for (int i = 1; i <= 3 + L + B + 1; i++) begin
      if (exp_dv[i]) cur = exp_d[i];
      acks += int'(got_s[i][5]);
      total++;
      if (got_s[i] !== exp_s[i]) begin
        bad++; $display("FAIL rd_wr c%0d strobes got=%b want=%b", i, got_s[i], exp_s[i]);
      end
      total++;
      if (got_d[i] !== cur) begin
        bad++; $display("FAIL rd_wr c%0d dout got=%h want=%h", i, got_d[i], cur);
      end
    end
    last_dout = cur;
    total++;
    if (acks !== 2) begin bad++; $display("FAIL rd_wr ack_count got=%0d want=2", acks); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_plan();
    addr = 12'h010; rd = 1'b1;
    exp_s[1][5] = 1'b1;
    exp_dv[2] = 1'b1; exp_d[2] = 16'h0;
    run(7, 1'b1, 1, -1);
    for (int j = 0; j < 2; j++) begin
      if (j == 1) begin
        clear_plan();
        issue(0, 12'h010, 16'h0, 2'b00, n);
        run(n, 1'b1, -1, -1);
      end else n = 7;
      cur = last_dout;
      for (int i = 1; i <= n; i++) begin
        if (exp_dv[i]) cur = exp_d[i];
        total++;
        if (got_s[i] !== exp_s[i]) begin
          bad++; $display("FAIL rst_mid op%0d c%0d strobes got=%b want=%b", j, i, got_s[i], exp_s[i]);
        end
        total++;
        if (got_d[i] !== cur) begin
          bad++; $display("FAIL rst_mid op%0d c%0d dout got=%h want=%h", j, i, got_d[i], cur);
        end
      end
      last_dout = cur;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    int n;
    for (int j = 0; j < 2; j++) begin
      clear_plan();
      d = 16'($urandom);
      if (j == 0) begin
        // write held high: re-sampled on the first idle cycle after rdy
        addr = 12'h050; din = d; din_m = 2'b00; wr = 1'b1;
        plan_write(12'h050, d, 2'b00, 0, 1'b0);
        plan_write(12'h050, d, 2'b00, 3, 1'b0);
        n = 5;
        run(n, 1'b0, -1, -1);
        wr = 1'b0;
        @(posedge clk); @(negedge clk);
      end else begin
        // download starts mid-read: read finishes, loader served next idle
        prog_addr = 12'h060; prog_data = d; prog_mask = 2'b00;
        addr = 12'h010; rd = 1'b1;
        plan_read(12'h010, 0);
        plan_write(12'h060, d, 2'b00, L + B + 1, 1'b1);
        n = L + B + 4;
        run(n, 1'b1, -1, 1);
        prog_en = 1'b0;
      end
      cur = last_dout;
      for (int i = 1; i <= n; i++) begin
        if (exp_dv[i]) cur = exp_d[i];
        total++;
        if (got_s[i] !== exp_s[i]) begin
          bad++; $display("FAIL b2b op%0d c%0d strobes got=%b want=%b", j, i, got_s[i], exp_s[i]);
        end
        total++;
        if (got_d[i] !== cur) begin
          bad++; $display("FAIL b2b op%0d c%0d dout got=%h want=%h", j, i, got_d[i], cur);
        end
      end
      last_dout = cur;
    end
  endtask

  task automatic test_random();
    int kind, n;
    logic [AW-1:0] a;
    for (int j = 0; j < 40; j++) begin
      clear_plan();
      if (j < 16) begin kind = 2; a = 12'h040 + AW'(j); end
      else begin kind = int'($urandom_range(0, 2)); a = 12'h040 + AW'($urandom_range(0, 14)); end
      issue(kind, a, 16'($urandom), (j < 16) ? 2'b00 : 2'($urandom_range(0, 3)), n);
      run(n, 1'b1, -1, -1);
      prog_en = 1'b0;
      cur = last_dout;
      for (int i = 1; i <= n; i++) begin
        if (exp_dv[i]) cur = exp_d[i];
        total++;
        if (got_s[i] !== exp_s[i]) begin
          bad++; $display("FAIL rand op%0d c%0d strobes got=%b want=%b", j, i, got_s[i], exp_s[i]);
        end
        total++;
        if (got_d[i] !== cur) begin
          bad++; $display("FAIL rand op%0d c%0d dout got=%h want=%h", j, i, got_d[i], cur);
        end
      end
      last_dout = cur;
    end
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0; din_m = '0;
    prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_mask = '0;
    last_dout = '0;
    test_reset();
    test_prog();
    test_read();
    test_write_mask();
    test_rd_wr();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
